// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a prescaled step tick drives one of four 4-bit patterns,
// and a synchronized, debounced mode button cycles BLINK -> CHASE -> PINGPONG -> COUNT.
module led_pattern_sequencer #(
  parameter int TICK_DIV     = 25_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_mode,
  input  logic       i_pause,
  output logic [3:0] o_led,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    MODE_BLINK    = 2'd0,
    MODE_CHASE    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_e;

  logic          btn_meta;
  logic          btn_sync;
  logic [DW-1:0] deb_cnt;
  logic          btn_deb;
  logic          mode_adv;
  logic [PW-1:0] presc;
  logic          tick_q;
  mode_e         state_q;
  mode_e         state_d;
  logic [3:0]    init_led;
  logic [3:0]    led_q;
  logic          dir_right;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= i_btn_mode;
      btn_sync <= btn_meta;
    end
  end

  // The level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples;
  // mode_adv fires on the accepted press, never on the release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt  <= '0;
      btn_deb  <= 1'b0;
      mode_adv <= 1'b0;
    end else begin
      mode_adv <= 1'b0;
      if (btn_sync != btn_deb) begin
        if (deb_cnt == DEB_LAST) begin
          btn_deb  <= ~btn_deb;
          deb_cnt  <= '0;
          mode_adv <= ~btn_deb;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A mode change restarts the step period so the new pattern gets a full first step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (mode_adv) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (i_pause) begin
      tick_q <= 1'b0;
    end else if (presc == PRESC_LAST) begin
      presc  <= '0;
      tick_q <= 1'b1;
    end else begin
      presc  <= presc + 1'b1;
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MODE_BLINK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_adv) begin
      unique case (state_q)
        MODE_BLINK:    state_d = MODE_CHASE;
        MODE_CHASE:    state_d = MODE_PINGPONG;
        MODE_PINGPONG: state_d = MODE_COUNT;
        MODE_COUNT:    state_d = MODE_BLINK;
      endcase
    end
  end

  always_comb begin
    o_mode   = state_q;
    init_led = 4'b0000;
    if (state_d == MODE_CHASE || state_d == MODE_PINGPONG) begin
      init_led = 4'b0001;
    end
  end

  // An advance overrides a coincident step: the new mode starts from its initial pattern.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q     <= 4'b0000;
      dir_right <= 1'b0;
    end else if (mode_adv) begin
      led_q     <= init_led;
      dir_right <= 1'b0;
    end else if (tick_q) begin
      unique case (state_q)
        MODE_BLINK: led_q <= ~led_q;
        MODE_CHASE: led_q <= {led_q[2:0], led_q[3]};
        MODE_PINGPONG: begin
          if (!dir_right) begin
            if (led_q[3]) begin
              dir_right <= 1'b1;
              led_q     <= 4'b0100;
            end else begin
              led_q <= led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_right <= 1'b0;
              led_q     <= 4'b0010;
            end else begin
              led_q <= led_q >> 1;
            end
          end
        end
        MODE_COUNT: led_q <= led_q + 4'd1;
      endcase
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;

endmodule
